// File: rtl/servo_pkg.sv
// Shared constants, state encodings and digit helpers for the servo command receiver.
package servo_pkg;

  localparam int ID_W   = 10;
  localparam int PWM_W  = 14;
  localparam int TIME_W = 14;

  localparam logic [7:0] ASCII_HASH = 8'h23;
  localparam logic [7:0] ASCII_P    = 8'h50;
  localparam logic [7:0] ASCII_T    = 8'h54;
  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;

  localparam logic [PWM_W-1:0] PWM_MIN = 14'd500;
  localparam logic [PWM_W-1:0] PWM_MAX = 14'd2500;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  typedef enum logic [2:0] {ST_IDLE, ST_ID, ST_P, ST_PWM, ST_T, ST_TIME, ST_END} parse_state_e;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

  function automatic logic [13:0] acc_digit(input logic [13:0] acc, input logic [7:0] b);
    logic [7:0] d;
    d = b - ASCII_ZERO;
    return (acc * 14'd10) + {6'd0, d};
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: two-flop synchroniser, start-bit glitch filter, centre sampling.
module uart_byte_rx
  import servo_pkg::*;
#(
  parameter int BPS_CNT = 434
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rxd,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int CNT_W = (BPS_CNT > 2) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BPS_CNT / 2 - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tick;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    sync1_d    = rxd;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    tick       = (cnt_q == '0);
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync2_q) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end
      RX_START: begin
        // a line that is high again at mid-bit was noise, not a start bit
        if (tick) begin
          if (!sync2_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_M1;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (tick) begin
          shift_d = {sync2_q, shift_q[7:1]};
          cnt_d   = FULL_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (tick) begin
          byte_valid = sync2_q;
          stop_err   = !sync2_q;
          state_d    = RX_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_data = shift_q;

endmodule

// File: rtl/servo_cmd_rx.sv
// Servo command parser for "#iiiPppppTtttt!" frames over UART.
// Optional pulse-width range check enabled by defining SERVO_RANGE_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for '#', everything else ignored
// ID      | collecting 3 ID digits
// P       | expecting 'P'
// PWM     | collecting 4 pulse-width digits
// T       | expecting 'T'
// TIME    | collecting 4 move-time digits
// END     | expecting '!'
module servo_cmd_rx
  import servo_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        uart_rxd,
  output logic [9:0]  cmd_id,
  output logic [13:0] cmd_pwm,
  output logic [13:0] cmd_time,
  output logic        cmd_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int BPS_CNT = CLK_FREQ / UART_BPS;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_stop_err;

  uart_byte_rx #(.BPS_CNT(BPS_CNT)) u_rx (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rxd       (uart_rxd),
    .byte_data (rx_byte),
    .byte_valid(rx_valid),
    .stop_err  (rx_stop_err)
  );

  parse_state_e      state_q, state_d;
  logic [2:0]        dcnt_q, dcnt_d;
  logic [ID_W-1:0]   id_acc_q, id_acc_d;
  logic [PWM_W-1:0]  pwm_acc_q, pwm_acc_d;
  logic [TIME_W-1:0] time_acc_q, time_acc_d;
  logic [ID_W-1:0]   cmd_id_q, cmd_id_d;
  logic [PWM_W-1:0]  cmd_pwm_q, cmd_pwm_d;
  logic [TIME_W-1:0] cmd_time_q, cmd_time_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              frame_err_q, frame_err_d;

  logic take_digit, bad_byte, start_frame, frame_done, digit;
  logic [13:0] id_tmp;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      dcnt_q      <= '0;
      id_acc_q    <= '0;
      pwm_acc_q   <= '0;
      time_acc_q  <= '0;
      cmd_id_q    <= '0;
      cmd_pwm_q   <= '0;
      cmd_time_q  <= '0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      id_acc_q    <= id_acc_d;
      pwm_acc_q   <= pwm_acc_d;
      time_acc_q  <= time_acc_d;
      cmd_id_q    <= cmd_id_d;
      cmd_pwm_q   <= cmd_pwm_d;
      cmd_time_q  <= cmd_time_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    take_digit  = 1'b0;
    bad_byte    = 1'b0;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    digit       = is_digit(rx_byte);
    if (rx_stop_err) begin
      state_d = ST_IDLE;
      dcnt_d  = '0;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == ASCII_HASH) begin
            state_d     = ST_ID;
            dcnt_d      = '0;
            start_frame = 1'b1;
          end
        end
        ST_ID, ST_PWM, ST_TIME: begin
          if (digit) begin
            take_digit = 1'b1;
            dcnt_d     = dcnt_q + 3'd1;
            if (state_q == ST_ID && dcnt_q == 3'd2) begin
              state_d = ST_P;
              dcnt_d  = '0;
            end else if (state_q != ST_ID && dcnt_q == 3'd3) begin
              state_d = (state_q == ST_PWM) ? ST_T : ST_END;
              dcnt_d  = '0;
            end
          end else begin
            bad_byte = 1'b1;
          end
        end
        ST_P:    if (rx_byte == ASCII_P) state_d = ST_PWM; else bad_byte = 1'b1;
        ST_T:    if (rx_byte == ASCII_T) state_d = ST_TIME; else bad_byte = 1'b1;
        ST_END: begin
          if (rx_byte == ASCII_BANG) begin
            frame_done = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            bad_byte = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
      // a stray '#' mid-frame is treated as the start of a fresh frame
      if (bad_byte) begin
        dcnt_d      = '0;
        start_frame = (rx_byte == ASCII_HASH);
        state_d     = start_frame ? ST_ID : ST_IDLE;
      end
    end
  end

  always_comb begin
    id_acc_d    = id_acc_q;
    pwm_acc_d   = pwm_acc_q;
    time_acc_d  = time_acc_q;
    cmd_id_d    = cmd_id_q;
    cmd_pwm_d   = cmd_pwm_q;
    cmd_time_d  = cmd_time_q;
    cmd_valid_d = 1'b0;
    frame_err_d = bad_byte | rx_stop_err;
    id_tmp      = acc_digit({4'd0, id_acc_q}, rx_byte);
    if (start_frame) begin
      id_acc_d   = '0;
      pwm_acc_d  = '0;
      time_acc_d = '0;
    end else if (take_digit) begin
      case (state_q)
        ST_ID:   id_acc_d   = id_tmp[ID_W-1:0];
        ST_PWM:  pwm_acc_d  = acc_digit(pwm_acc_q, rx_byte);
        ST_TIME: time_acc_d = acc_digit(time_acc_q, rx_byte);
        default: ;
      endcase
    end
    if (frame_done) begin
`ifdef SERVO_RANGE_CHECK_EN
      if (pwm_acc_q < PWM_MIN || pwm_acc_q > PWM_MAX) begin
        frame_err_d = 1'b1;
      end else begin
        cmd_id_d    = id_acc_q;
        cmd_pwm_d   = pwm_acc_q;
        cmd_time_d  = time_acc_q;
        cmd_valid_d = 1'b1;
      end
`else
      cmd_id_d    = id_acc_q;
      cmd_pwm_d   = pwm_acc_q;
      cmd_time_d  = time_acc_q;
      cmd_valid_d = 1'b1;
`endif
    end
  end

  assign cmd_id    = cmd_id_q;
  assign cmd_pwm   = cmd_pwm_q;
  assign cmd_time  = cmd_time_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
